// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes/InvSubBytes engine: LANES S-box lookups per cycle over the 16 state bytes.
// Define SUB_BYTES_FWD_EN to build the forward tables; otherwise every block is InvSubBytes.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy,
    output logic [1:0]   dbg_state_o
);
    localparam int N = 16 / LANES;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_lut(input logic [7:0] x);
        return INV_SBOX[{x, 3'b000} +: 8];
    endfunction

    // Handshake: a block enters on in_valid && in_ready and leaves on out_valid && out_ready;
    // in_ready in DONE follows out_ready so a new block can enter on the same edge one leaves.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [0:127] data_q, data_d;
    logic [0:127] sub_data;
    logic [3:0]   base;
    logic         last_grp;
    logic         load;

`ifdef SUB_BYTES_FWD_EN
    localparam logic [0:2047] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] fwd_lut(input logic [7:0] x);
        return FWD_SBOX[{x, 3'b000} +: 8];
    endfunction

    logic inv_q, inv_d;

    assign inv_d = load ? in_inv : inv_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) inv_q <= 1'b0;
        else          inv_q <= inv_d;
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    if (N > 1) begin : g_grp
        localparam int GW = $clog2(N);
        logic [GW-1:0] grp_q, grp_d;

        assign last_grp = (grp_q == GW'(N - 1));
        assign grp_d    = (state_q == BUSY && !last_grp) ? grp_q + 1'b1 : '0;
        assign base     = 4'(grp_q) * 4'(LANES);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) grp_q <= '0;
            else          grp_q <= grp_d;
        end
    end else begin : g_one
        assign last_grp = 1'b1;
        assign base     = 4'd0;
    end

    always_comb begin
        sub_data = data_q;
        for (int l = 0; l < LANES; l++) begin
`ifdef SUB_BYTES_FWD_EN
            sub_data[8 * (int'(base) + l) +: 8] = inv_q ? inv_lut(data_q[8 * (int'(base) + l) +: 8])
                                                        : fwd_lut(data_q[8 * (int'(base) + l) +: 8]);
`else
            sub_data[8 * (int'(base) + l) +: 8] = inv_lut(data_q[8 * (int'(base) + l) +: 8]);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last_grp) state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_d = load ? in_data : ((state_q == BUSY) ? sub_data : data_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // The result is masked outside DONE so a half-substituted state never reaches out_data.
    assign out_valid   = (state_q == DONE);
    assign out_data    = out_valid ? data_q : '0;
    assign busy        = (state_q == BUSY);
    assign in_ready    = reset_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: three instances (LANES 4, 1, 16) checked against a GF(2^8) S-box model.
module tb_sub_bytes_engine;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid  [NDUT];
    logic         in_inv    [NDUT];
    logic         out_ready [NDUT];
    logic         in_ready  [NDUT];
    logic         out_valid [NDUT];
    logic         busy      [NDUT];
    logic [0:127] in_data   [NDUT];
    logic [0:127] out_data  [NDUT];
    logic [1:0]   dbg_state [NDUT];

    int lat [NDUT];
    int checks = 0;
    int errors = 0;
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    logic [0:127] exp_q[$];

    sub_bytes_engine #(.LANES(4)) u_l4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0]), .dbg_state_o(dbg_state[0]));
    sub_bytes_engine #(.LANES(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1]), .dbg_state_o(dbg_state[1]));
    sub_bytes_engine #(.LANES(16)) u_l16 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2]), .dbg_state_o(dbg_state[2]));

    // ---------------- reference model: S-box from GF(2^8) inverse + affine map ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        logic hi;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x = {x[6:0], 1'b0};
            if (hi) x = x ^ 8'h1b;
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] b, s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [0:127] model_block(input logic [0:127] d, input logic inv);
        logic [0:127] r;
        logic [7:0] b;
        logic use_inv;
`ifdef SUB_BYTES_FWD_EN
        use_inv = inv;
`else
        use_inv = 1'b1;
`endif
        for (int k = 0; k < 16; k++) begin
            b = d[8 * k +: 8];
            r[8 * k +: 8] = use_inv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks (inputs change 1 time unit after the rising edge) ----------------
    task automatic idle_all();
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0; in_inv[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b0;
        end
    endtask

    task automatic accept_block(input int d, input logic [0:127] din, input logic inv, output bit ok);
        bit acc;
        ok = 1'b0;
        in_valid[d] = 1'b1; in_data[d] = din; in_inv[d] = inv;
        for (int i = 0; i < 40; i++) begin
            #1;
            acc = in_ready[d];
            @(posedge clk);
            #1;
            if (acc) begin ok = 1'b1; break; end
        end
        in_valid[d] = 1'b0;
        in_data[d] = rand128();
        in_inv[d] = ~inv;
    endtask

    task automatic wait_valid(input int d, output int cyc);
        cyc = 0;
        while (out_valid[d] !== 1'b1 && cyc < 64) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (out_valid[d] !== 1'b1) cyc = -1;
    endtask

    task automatic drain(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic run_block(input int d, input logic [0:127] din, input logic inv,
                             output int cyc, output logic [0:127] dout);
        bit ok;
        accept_block(d, din, inv, ok);
        if (!ok) begin cyc = -1; dout = '0; return; end
        wait_valid(d, cyc);
        dout = out_data[d];
        drain(d);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (in_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d]: got %b want 0", d, in_ready[d]); end
            checks++;
            if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", d, out_valid[d]); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0) begin errors++; $display("FAIL idle_out_valid[%0d]: got %b want 0", d, out_valid[d]); end
            checks++;
            if (out_data[d] !== 128'h0) begin errors++; $display("FAIL idle_out_data[%0d]: got %h want 0", d, out_data[d]); end
            checks++;
            if (busy[d] !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d]: got %b want 0", d, busy[d]); end
            checks++;
            if (in_ready[d] !== 1'b1) begin errors++; $display("FAIL idle_in_ready[%0d]: got %b want 1", d, in_ready[d]); end
        end
    endtask

    task automatic test_vectors();
        logic [0:127] vin [4];
        logic [0:127] vexp [4];
        logic         vinv [4];
        logic [0:127] dout;
        int nvec, cyc;
`ifdef SUB_BYTES_FWD_EN
        nvec = 4;
        vin[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; vinv[0] = 1'b0; vexp[0] = 128'hd42711aee0bf98f1b8b45de51e415230;
        vin[1] = 128'hd42711aee0bf98f1b8b45de51e415230; vinv[1] = 1'b1; vexp[1] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        vin[2] = 128'h0;                                vinv[2] = 1'b1; vexp[2] = {16{8'h52}};
        vin[3] = {16{8'h53}};                        vinv[3] = 1'b0; vexp[3] = {16{8'hed}};
`else
        nvec = 3;
        vin[0] = 128'hd42711aee0bf98f1b8b45de51e415230; vinv[0] = 1'b1; vexp[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        vin[1] = 128'h0;                                vinv[1] = 1'b1; vexp[1] = {16{8'h52}};
        vin[2] = 128'h0;                                vinv[2] = 1'b0; vexp[2] = {16{8'h52}};
        vin[3] = 128'h0;                                vinv[3] = 1'b0; vexp[3] = 128'h0;
`endif
        for (int i = 0; i < nvec; i++) begin
            run_block(0, vin[i], vinv[i], cyc, dout);
            checks++;
            if (dout !== vexp[i]) begin errors++; $display("FAIL vector%0d_data: got %h want %h", i, dout, vexp[i]); end
            checks++;
            if (cyc != 4) begin errors++; $display("FAIL vector%0d_latency: got %0d want 4", i, cyc); end
        end
    endtask

    task automatic test_random();
        logic [0:127] din, dout, want;
        logic inv;
        int cyc;
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 5; i++) begin
                din = rand128();
                inv = 1'($urandom_range(0, 1));
                want = model_block(din, inv);
                run_block(d, din, inv, cyc, dout);
                checks++;
                if (dout !== want) begin errors++; $display("FAIL random_data[%0d.%0d]: got %h want %h", d, i, dout, want); end
                checks++;
                if (cyc != lat[d]) begin errors++; $display("FAIL random_latency[%0d.%0d]: got %0d want %0d", d, i, cyc, lat[d]); end
            end
        end
    endtask

    task automatic test_mode_latch();
        logic [0:127] din, dout, want;
        int cyc;
        bit ok;
        for (int m = 0; m < 2; m++) begin
            din = rand128();
            want = model_block(din, 1'(m));
            accept_block(0, din, 1'(m), ok);
            in_valid[0] = 1'b1; in_inv[0] = ~1'(m); in_data[0] = ~din;
            wait_valid(0, cyc);
            dout = out_data[0];
            in_valid[0] = 1'b0;
            drain(0);
            checks++;
            if (!ok || dout !== want) begin errors++; $display("FAIL mode_latch%0d_data: got %h want %h", m, dout, want); end
            checks++;
            if (cyc != 4) begin errors++; $display("FAIL mode_latch%0d_latency: got %0d want 4", m, cyc); end
        end
    endtask

    task automatic test_backpressure();
        logic [0:127] din_a, din_b, want_a, want_b;
        logic inv_a, inv_b;
        int cyc;
        bit ok;
        din_a = rand128(); inv_a = 1'($urandom_range(0, 1)); want_a = model_block(din_a, inv_a);
        din_b = rand128(); inv_b = 1'($urandom_range(0, 1)); want_b = model_block(din_b, inv_b);
        accept_block(0, din_a, inv_a, ok);
        wait_valid(0, cyc);
        checks++;
        if (cyc != 4) begin errors++; $display("FAIL bp_latency_a: got %0d want 4", cyc); end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== want_a || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h in_ready=%b want valid=1 data=%h in_ready=0",
                         i, out_valid[0], out_data[0], in_ready[0], want_a);
            end
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = din_b; in_inv[0] = inv_b;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_zero_bubble_ready: got %b want 1", in_ready[0]); end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0; in_valid[0] = 1'b0; in_data[0] = rand128();
        checks++;
        if (busy[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++; $display("FAIL bp_next_busy: got busy=%b valid=%b want busy=1 valid=0", busy[0], out_valid[0]);
        end
        wait_valid(0, cyc);
        checks++;
        if (cyc != 4) begin errors++; $display("FAIL bp_latency_b: got %0d want 4", cyc); end
        checks++;
        if (out_data[0] !== want_b) begin errors++; $display("FAIL bp_data_b: got %h want %h", out_data[0], want_b); end
        drain(0);
    endtask

    task automatic test_back_to_back();
        logic [0:127] cur, od, want;
        logic cur_inv, ov, ir, iv;
        int sent, got, overlap;
        for (int d = 0; d < NDUT; d++) begin
            exp_q.delete();
            sent = 0; got = 0; overlap = 0;
            cur = rand128(); cur_inv = 1'($urandom_range(0, 1));
            out_ready[d] = 1'b1; in_valid[d] = 1'b1; in_data[d] = cur; in_inv[d] = cur_inv;
            for (int c = 0; c < 200 && got < 4; c++) begin
                #1;
                ov = out_valid[d]; ir = in_ready[d]; od = out_data[d]; iv = in_valid[d];
                if (ov) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL b2b_unexpected[%0d]: got %h want no output", d, od);
                    end else begin
                        want = exp_q.pop_front();
                        if (od !== want) begin errors++; $display("FAIL b2b_data[%0d.%0d]: got %h want %h", d, got, od, want); end
                    end
                    got++;
                end
                if (iv && ir) begin
                    exp_q.push_back(model_block(cur, cur_inv));
                    sent++;
                    if (ov) overlap++;
                end
                @(posedge clk);
                #1;
                if (iv && ir) begin
                    if (sent < 4) begin
                        cur = rand128(); cur_inv = 1'($urandom_range(0, 1));
                        in_data[d] = cur; in_inv[d] = cur_inv;
                    end else begin
                        in_valid[d] = 1'b0;
                    end
                end
            end
            in_valid[d] = 1'b0; out_ready[d] = 1'b0;
            checks++;
            if (got != 4 || exp_q.size() != 0) begin
                errors++; $display("FAIL b2b_count[%0d]: got %0d outputs (%0d pending) want 4 (0 pending)", d, got, exp_q.size());
            end
            checks++;
            if (overlap != 3) begin errors++; $display("FAIL b2b_overlap[%0d]: got %0d want 3", d, overlap); end
        end
    endtask

    task automatic test_reset_mid();
        logic [0:127] din, dout, want;
        logic inv;
        int cyc, leak;
        bit ok;
        for (int d = 0; d < NDUT; d++) begin
            accept_block(d, rand128(), 1'($urandom_range(0, 1)), ok);
            @(posedge clk);
            #1;
            reset_n = 1'b0;
            #1;
            checks++;
            if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_async[%0d]: got valid=%b busy=%b in_ready=%b want 0 0 0",
                         d, out_valid[d], busy[d], in_ready[d]);
            end
            @(posedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            @(posedge clk);
            #1;
            leak = 0;
            for (int i = 0; i < 20; i++) begin
                if (out_valid[d] !== 1'b0) leak++;
                @(posedge clk);
                #1;
            end
            checks++;
            if (leak != 0) begin errors++; $display("FAIL midreset_leak[%0d]: got %0d valid cycles want 0", d, leak); end
            din = rand128(); inv = 1'($urandom_range(0, 1)); want = model_block(din, inv);
            run_block(d, din, inv, cyc, dout);
            checks++;
            if (dout !== want) begin errors++; $display("FAIL midreset_next_data[%0d]: got %h want %h", d, dout, want); end
            checks++;
            if (cyc != lat[d]) begin errors++; $display("FAIL midreset_next_latency[%0d]: got %0d want %0d", d, cyc, lat[d]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lat[0] = 4; lat[1] = 16; lat[2] = 1;
        idle_all();
        build_tables();
        test_reset();
        test_vectors();
        test_random();
        test_mode_latch();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
